argmax_classifier: RTL and testbench



---
 rtl/argmax_classifier.sv | 128 ++++++++++++
 tb/tb_argmax_classifier.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/argmax_classifier.sv
// Sequential argmax over a captured vector of signed fixed-point activations.
// One element is compared per cycle; the lowest index wins on ties.
module argmax_classifier #(
  parameter int numInputs  = 10,
  parameter int dataWidth  = 16,
  parameter int indexWidth = $clog2(numInputs)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [dataWidth*numInputs-1:0] classIn,
  input  logic                           classInValid,
  output logic [indexWidth-1:0]          classOut,
  output logic [dataWidth-1:0]           maxOut,
  output logic                           classOutValid,
  output logic                           busy,
  output logic                           dropped
);

  localparam int CntW = $clog2(numInputs + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(numInputs - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, SCAN = 1'b1} state_e;

  state_e                       state_q, state_d;
  logic signed [dataWidth-1:0]  buf_q [numInputs];
  logic [CntW-1:0]              cnt_q, cnt_d;
  logic signed [dataWidth-1:0]  run_max_q, run_max_d;
  logic [indexWidth-1:0]        run_idx_q, run_idx_d;
  logic [indexWidth-1:0]        class_q, class_d;
  logic [dataWidth-1:0]         max_q, max_d;
  logic                         valid_q, valid_d;
  logic                         dropped_q, dropped_d;
  logic                         load_s;
  logic signed [dataWidth-1:0]  elem_s;
  logic                         greater_s;

  assign elem_s    = buf_q[cnt_q[indexWidth-1:0]];
  assign greater_s = (elem_s > run_max_q);

  // Next-state and result selection for the capture/scan FSM
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    run_max_d = run_max_q;
    run_idx_d = run_idx_q;
    class_d   = class_q;
    max_d     = max_q;
    valid_d   = 1'b0;
    dropped_d = 1'b0;
    load_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (classInValid) begin
          load_s    = 1'b1;
          run_max_d = classIn[dataWidth-1:0];
          run_idx_d = {indexWidth{1'b0}};
          cnt_d     = CntW'(1);
          state_d   = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        dropped_d = classInValid;
        if (greater_s) begin
          run_max_d = elem_s;
          run_idx_d = cnt_q[indexWidth-1:0];
        end else begin
          run_max_d = run_max_q;
        end
        // The last compare feeds the published result directly.
        if (cnt_q == LastCnt) begin
          class_d = run_idx_d;
          max_d   = run_max_d;
          valid_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, scan registers and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= {CntW{1'b0}};
      run_max_q <= {dataWidth{1'b0}};
      run_idx_q <= {indexWidth{1'b0}};
      class_q   <= {indexWidth{1'b0}};
      max_q     <= {dataWidth{1'b0}};
      valid_q   <= 1'b0;
      dropped_q <= 1'b0;
      for (int k = 0; k < numInputs; k++) begin
        buf_q[k] <= {dataWidth{1'b0}};
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      run_max_q <= run_max_d;
      run_idx_q <= run_idx_d;
      class_q   <= class_d;
      max_q     <= max_d;
      valid_q   <= valid_d;
      dropped_q <= dropped_d;
      if (load_s) begin
        for (int k = 0; k < numInputs; k++) begin
          buf_q[k] <= classIn[k*dataWidth +: dataWidth];
        end
      end else begin
        for (int k = 0; k < numInputs; k++) begin
          buf_q[k] <= buf_q[k];
        end
      end
    end
  end

  assign classOut      = class_q;
  assign maxOut        = max_q;
  assign classOutValid = valid_q;
  assign busy          = (state_q == SCAN);
  assign dropped       = dropped_q;

endmodule

// File: tb/tb_argmax_classifier.sv
// Randomized and directed bench for argmax_classifier against a transaction-level
// model: acceptance windows by edge arithmetic, results by a plain argmax loop.
module tb_argmax_classifier;

  localparam int N  = 10;
  localparam int DW = 16;
  localparam int IW = $clog2(N);

  logic              clk;
  logic              reset;
  logic [DW*N-1:0]   class_in;
  logic              class_in_valid;
  logic [IW-1:0]     class_out;
  logic [DW-1:0]     max_out;
  logic              class_out_valid;
  logic              busy;
  logic              dropped;

  int n_vec;
  int n_err;
  int edge_n;
  int last_acc;
  bit in_rst;

  logic [IW-1:0] exp_cls, pend_cls;
  logic [DW-1:0] exp_max, pend_max;
  logic          exp_valid, exp_busy, exp_drop;

  argmax_classifier #(.numInputs(N), .dataWidth(DW)) dut (
    .clk(clk), .reset(reset), .classIn(class_in), .classInValid(class_in_valid),
    .classOut(class_out), .maxOut(max_out), .classOutValid(class_out_valid),
    .busy(busy), .dropped(dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  function automatic logic [DW*N-1:0] fill_vec(input logic [DW-1:0] val);
    logic [DW*N-1:0] v;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = val;
    return v;
  endfunction

  function automatic logic [DW*N-1:0] rand_vec();
    logic [DW*N-1:0] v;
    logic [DW-1:0]   pick [4];
    int mode;
    pick[0] = 16'h8000; pick[1] = 16'h7FFF; pick[2] = 16'h0000; pick[3] = 16'hFFFF;
    mode = $urandom_range(0, 2);
    for (int k = 0; k < N; k++) begin
      if (mode == 0)      v[k*DW +: DW] = DW'($urandom);
      else if (mode == 1) v[k*DW +: DW] = pick[$urandom_range(0, 3)];
      else                v[k*DW +: DW] = DW'($urandom_range(0, 3)) - 16'd1;
    end
    return v;
  endfunction

  task automatic ref_argmax(input logic [DW*N-1:0] v, output logic [IW-1:0] c, output logic [DW-1:0] m);
    int best_i;
    int best_v;
    best_i = 0;
    best_v = $signed(v[DW-1:0]);
    for (int k = 1; k < N; k++) begin
      if ($signed(v[k*DW +: DW]) > best_v) begin
        best_v = $signed(v[k*DW +: DW]);
        best_i = k;
      end
    end
    c = IW'(best_i);
    m = DW'(best_v);
  endtask

  task automatic check_outputs(input string where);
    check_val({where, "_valid"},   {31'd0, class_out_valid}, {31'd0, exp_valid});
    check_val({where, "_busy"},    {31'd0, busy},            {31'd0, exp_busy});
    check_val({where, "_dropped"}, {31'd0, dropped},         {31'd0, exp_drop});
    check_val({where, "_class"},   32'(class_out),           32'(exp_cls));
    check_val({where, "_max"},     32'(max_out),             32'(exp_max));
  endtask

  // One clock: apply inputs, advance the model at the edge, compare at the falling edge.
  task automatic step(input logic vin, input logic [DW*N-1:0] vec, input string where);
    class_in       = vec;
    class_in_valid = vin;
    @(posedge clk);
    edge_n++;
    exp_valid = 1'b0;
    exp_drop  = 1'b0;
    exp_busy  = 1'b0;
    if (in_rst) begin
      exp_cls = '0;
      exp_max = '0;
    end else begin
      if (edge_n == last_acc + N - 1) begin
        exp_valid = 1'b1;
        exp_cls   = pend_cls;
        exp_max   = pend_max;
      end
      if (vin) begin
        if (edge_n >= last_acc + N) begin
          last_acc = edge_n;
          ref_argmax(vec, pend_cls, pend_max);
        end else begin
          exp_drop = 1'b1;
        end
      end
      exp_busy = (edge_n >= last_acc) && (edge_n <= last_acc + N - 2);
    end
    @(negedge clk);
    check_outputs(where);
  endtask

  task automatic idle(input int cycles, input string where);
    repeat (cycles) step(1'b0, rand_vec(), where);
  endtask

  task automatic do_reset(input int cycles);
    reset          = 1'b0;
    class_in       = rand_vec();
    class_in_valid = 1'b1;
    in_rst         = 1'b1;
    last_acc       = -1000;
    exp_cls = '0; exp_max = '0; exp_valid = 1'b0; exp_busy = 1'b0; exp_drop = 1'b0;
    #1;
    check_outputs("rst_async");
    repeat (cycles) step(1'b1, rand_vec(), "rst_hold");
    reset  = 1'b1;
    in_rst = 1'b0;
  endtask

  initial begin
    logic [DW*N-1:0] v;
    n_vec = 0; n_err = 0; edge_n = 0; last_acc = -1000; in_rst = 1'b0;
    pend_cls = '0; pend_max = '0;
    reset = 1'b1; class_in = '0; class_in_valid = 1'b0;
    @(negedge clk);
    do_reset(3);
    idle(3, "post_rst");

    // max at index 7
    v = fill_vec(16'h0000); v[7*DW +: DW] = 16'h0C00;
    step(1'b1, v, "idx7");
    idle(10, "idx7");
    check_val("idx7_class", 32'(class_out), 32'd7);
    check_val("idx7_max", 32'(max_out), 32'h0C00);

    // negative tie: lowest index wins
    v = fill_vec(16'hF800); v[2*DW +: DW] = 16'hFC00; v[5*DW +: DW] = 16'hFC00;
    step(1'b1, v, "tie");
    idle(10, "tie");
    check_val("tie_class", 32'(class_out), 32'd2);
    check_val("tie_max", 32'(max_out), 32'hFC00);

    // max at index 0, extreme values
    v = fill_vec(16'h8000); v[DW-1:0] = 16'h7FFF;
    step(1'b1, v, "idx0");
    idle(10, "idx0");
    check_val("idx0_class", 32'(class_out), 32'd0);

    // back-to-back: second vector during first result cycle, then a drop mid-scan
    v = fill_vec(16'h0000); v[3*DW +: DW] = 16'h0100;
    step(1'b1, v, "b2b_a");
    idle(N - 1, "b2b_a");
    v = fill_vec(16'h0000); v[9*DW +: DW] = 16'h0400;
    step(1'b1, v, "b2b_b");
    idle(2, "b2b_b");
    step(1'b1, fill_vec(16'h7000), "b2b_drop");
    idle(10, "b2b_b");
    check_val("b2b_class", 32'(class_out), 32'd9);

    // reset mid-scan, then a normal vector
    step(1'b1, rand_vec(), "midrst");
    idle(3, "midrst");
    @(posedge clk); #2;
    do_reset(2);
    idle(2, "post_midrst");
    v = fill_vec(16'hFFF0); v[4*DW +: DW] = 16'h0001;
    step(1'b1, v, "after_rst");
    idle(10, "after_rst");
    check_val("after_rst_class", 32'(class_out), 32'd4);

    // randomized traffic with random gaps
    for (int i = 0; i < 1000; i++) begin
      step(1'b1, rand_vec(), "rand");
      idle($urandom_range(0, 12), "rand");
    end
    idle(N + 2, "drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
